// File: rtl/ball_sprite_drawer.sv
// Ball sprite address generator and palette-index pipeline with frame-synchronous position updates.
// Optional build macro: BALL_BBOX_DEBUG_EN outlines the sprite bounding box on transparent pixels.
module ball_sprite_drawer #(
  parameter logic [9:0] X_INIT    = 10'd320,
  parameter logic [9:0] Y_INIT    = 10'd240,
  parameter logic [1:0] SIZE_INIT = 2'd1,
  parameter int         ADDR_W    = 19,
  parameter logic [3:0] TRANSP    = 4'h0
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              VGA_VS,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              pix_valid,
  input  logic              pos_we,
  input  logic [9:0]        BallX_in,
  input  logic [9:0]        BallY_in,
  input  logic [1:0]        size_in,
  output logic              pos_pending,
  output logic [1:0]        ball_size,
  output logic [ADDR_W-1:0] read_address,
  input  logic [3:0]        rom_data,
  output logic              is_ball,
  output logic [3:0]        ball_idx,
  output logic              out_valid
);

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [1:0] size;
  } ball_t;

  localparam ball_t BALL_INIT = '{x: X_INIT, y: Y_INIT, size: SIZE_INIT};

  ball_t committed;
  ball_t shadow;
  ball_t incoming;
  logic  vs_d;
  logic  vs_fall;

  assign incoming  = '{x: BallX_in, y: BallY_in, size: size_in};
  assign vs_fall   = vs_d & ~VGA_VS;
  assign ball_size = committed.size;

  // Shadow/committed double buffer; a write landing on the commit edge bypasses the shadow.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      committed   <= BALL_INIT;
      shadow      <= BALL_INIT;
      pos_pending <= 1'b0;
      vs_d        <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments keep every register here reading pre-edge values.
      vs_d <= VGA_VS;
      if (pos_we)
        shadow <= incoming;
      if (vs_fall && (pos_pending || pos_we)) begin
        committed   <= pos_we ? incoming : shadow;
        pos_pending <= 1'b0;
      end else if (pos_we) begin
        pos_pending <= 1'b1;
      end
    end
  end

  logic        [4:0]  radius;
  logic        [5:0]  diam;
  logic signed [10:0] left_edge;
  logic signed [10:0] top_edge;
  logic signed [10:0] dx;
  logic signed [10:0] dy;
  logic               in_box;
  logic        [9:0]  dx_u;
  logic        [9:0]  dy_u;
  logic        [9:0]  diam_u;
  logic        [9:0]  pix_addr;

  always_comb begin
    // NOTE: default first so every path assigns radius and no latch is inferred.
    radius = 5'd15;
    case (committed.size)
      2'd0:    radius = 5'd5;
      2'd1:    radius = 5'd10;
      default: radius = 5'd15;
    endcase
  end

  assign diam = {radius, 1'b0};

  // Signed offsets from the box corner; a ball hanging off the left/top edge gives a negative corner.
  assign left_edge = $signed({1'b0, committed.x}) - $signed({6'b0, radius});
  assign top_edge  = $signed({1'b0, committed.y}) - $signed({6'b0, radius});
  assign dx        = $signed({1'b0, DrawX}) - left_edge;
  assign dy        = $signed({1'b0, DrawY}) - top_edge;

  assign in_box = pix_valid
                & ~dx[10] & (dx < $signed({5'b0, diam}))
                & ~dy[10] & (dy < $signed({5'b0, diam}));

  assign dx_u     = {4'b0, dx[5:0]};
  assign dy_u     = {4'b0, dy[5:0]};
  assign diam_u   = {4'b0, diam};
  assign pix_addr = dy_u * diam_u + dx_u;

  logic in_box_d1;
  logic pix_valid_d1;

`ifdef BALL_BBOX_DEBUG_EN
  logic on_border;
  logic on_border_d1;

  assign on_border = (dx[5:0] == 6'd0) || (dy[5:0] == 6'd0)
                   || (dx[5:0] == diam - 6'd1) || (dy[5:0] == diam - 6'd1);
`endif

  // Stage 1: ROM address plus the per-pixel flags that travel with it.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      read_address <= '0;
      in_box_d1    <= 1'b0;
      pix_valid_d1 <= 1'b0;
`ifdef BALL_BBOX_DEBUG_EN
      on_border_d1 <= 1'b0;
`endif
    end else begin
      read_address <= in_box ? ADDR_W'(pix_addr) : '0;
      in_box_d1    <= in_box;
      pix_valid_d1 <= pix_valid;
`ifdef BALL_BBOX_DEBUG_EN
      on_border_d1 <= on_border;
`endif
    end
  end

  // Stage 2: capture the combinational ROM result and resolve transparency.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      is_ball   <= 1'b0;
      ball_idx  <= 4'h0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= pix_valid_d1;
      ball_idx  <= rom_data;
      is_ball   <= in_box_d1 & (rom_data != TRANSP);
`ifdef BALL_BBOX_DEBUG_EN
      if (in_box_d1 && (rom_data == TRANSP) && on_border_d1) begin
        is_ball  <= 1'b1;
        ball_idx <= 4'hF;
      end
`endif
    end
  end

endmodule

// File: tb/tb_ball_sprite_drawer.sv
// Self-checking bench for ball_sprite_drawer: directed scenarios then randomized frames,
// compared against a pixel-level reference model with a synthetic sprite ROM.
module tb_ball_sprite_drawer;

  logic        clk;
  logic        rst_n;
  logic        vga_vs;
  logic [9:0]  drawx;
  logic [9:0]  drawy;
  logic        pix_valid;
  logic        pos_we;
  logic [9:0]  ballx_in;
  logic [9:0]  bally_in;
  logic [1:0]  size_in;
  logic        pos_pending;
  logic [1:0]  ball_size;
  logic [18:0] read_address;
  logic [3:0]  rom_data;
  logic        is_ball;
  logic [3:0]  ball_idx;
  logic        out_valid;

  ball_sprite_drawer dut (
    .Clk          (clk),
    .Reset_n      (rst_n),
    .VGA_VS       (vga_vs),
    .DrawX        (drawx),
    .DrawY        (drawy),
    .pix_valid    (pix_valid),
    .pos_we       (pos_we),
    .BallX_in     (ballx_in),
    .BallY_in     (bally_in),
    .size_in      (size_in),
    .pos_pending  (pos_pending),
    .ball_size    (ball_size),
    .read_address (read_address),
    .rom_data     (rom_data),
    .is_ball      (is_ball),
    .ball_idx     (ball_idx),
    .out_valid    (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synthetic combinational sprite ROM: every third address is transparent.
  function automatic logic [3:0] rom_f(int a);
    if (a % 3 == 0) return 4'h0;
    return 4'((a % 15) + 1);
  endfunction

  assign rom_data = rom_f(int'(read_address));

  typedef struct {
    int x;
    int y;
    int sz;
  } ball_m;

  typedef struct {
    int addr;
    bit inbox;
    bit pv;
    bit border;
  } pix_m;

  ball_m com;
  ball_m sh;
  bit    pend;
  bit    vs_prev;
  pix_m  cur;
  int    total = 0;
  int    bad   = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic pix_m pixel_of(int px, int py, bit pv, ball_m b);
    pix_m p;
    int r, d, dx, dy;
    r = (b.sz == 0) ? 5 : (b.sz == 1) ? 10 : 15;
    d = 2 * r;
    dx = px - (b.x - r);
    dy = py - (b.y - r);
    p.pv     = pv;
    p.inbox  = pv && dx >= 0 && dx < d && dy >= 0 && dy < d;
    p.addr   = p.inbox ? dy * d + dx : 0;
    p.border = (dx == 0) || (dy == 0) || (dx == d - 1) || (dy == d - 1);
    return p;
  endfunction

  // One clock: advance the model by one edge and compare every output.
  task automatic tick();
    pix_m       nr;
    ball_m      inb;
    bit         e_ib;
    logic [3:0] e_idx;
    bit         e_ov;
    nr  = pixel_of(int'(drawx), int'(drawy), pix_valid, com);
    inb = '{int'(ballx_in), int'(bally_in), int'(size_in)};
    @(posedge clk);
    #1;
    if (!rst_n) begin
      com     = '{320, 240, 1};
      sh      = '{320, 240, 1};
      pend    = 1'b0;
      vs_prev = 1'b1;
      cur     = '{0, 1'b0, 1'b0, 1'b0};
      e_ib    = 1'b0;
      e_idx   = 4'h0;
      e_ov    = 1'b0;
    end else begin
      e_ov  = cur.pv;
      e_idx = rom_f(cur.addr);
      e_ib  = cur.inbox && (e_idx != 4'h0);
`ifdef BALL_BBOX_DEBUG_EN
      if (cur.inbox && e_idx == 4'h0 && cur.border) begin
        e_ib  = 1'b1;
        e_idx = 4'hF;
      end
`endif
      if (vs_prev && !vga_vs && (pend || pos_we)) begin
        com  = pos_we ? inb : sh;
        pend = 1'b0;
        if (pos_we) sh = inb;
      end else if (pos_we) begin
        sh   = inb;
        pend = 1'b1;
      end
      vs_prev = vga_vs;
      cur     = nr;
    end
    check("read_address", 32'(read_address), 32'(cur.addr));
    check("is_ball", 32'(is_ball), 32'(e_ib));
    check("ball_idx", 32'(ball_idx), 32'(e_idx));
    check("out_valid", 32'(out_valid), 32'(e_ov));
    check("pos_pending", 32'(pos_pending), 32'(pend));
    check("ball_size", 32'(ball_size), 32'(com.sz[1:0]));
  endtask

  task automatic set_pix(int x, int y, bit v);
    drawx     = 10'(x);
    drawy     = 10'(y);
    pix_valid = v;
  endtask

  task automatic set_we(bit we, int x, int y, int s);
    pos_we   = we;
    ballx_in = 10'(x);
    bally_in = 10'(y);
    size_in  = 2'(s);
  endtask

  // Write a ball and commit it with a full VGA_VS high-low-high cycle.
  task automatic load_ball(int x, int y, int s);
    set_pix(0, 0, 1'b0);
    vga_vs = 1'b1;
    set_we(1'b1, x, y, s);
    tick();
    set_we(1'b0, 0, 0, 0);
    vga_vs = 1'b0;
    tick();
    vga_vs = 1'b1;
    tick();
  endtask

  function automatic int clampi(int v, int lo, int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  function automatic int pick_coord(int hi);
    case ($urandom_range(0, 3))
      0:       return int'($urandom_range(0, 20));
      1:       return int'($urandom_range(hi - 20, hi));
      default: return int'($urandom_range(0, hi));
    endcase
  endfunction

  initial begin
    rst_n  = 1'b0;
    vga_vs = 1'b1;
    set_pix(0, 0, 1'b0);
    set_we(1'b0, 0, 0, 0);

    // Reset held for two clocks.
    tick();
    tick();
    check("reset_size", 32'(ball_size), 32'd1);
    check("reset_pending", 32'(pos_pending), 32'd0);
    rst_n = 1'b1;
    tick();

    // Ball (100,100) size 1: box corner at (90,90).
    load_ball(100, 100, 1);
    set_pix(90, 90, 1'b1);
    tick();
    check("corner_addr", 32'(read_address), 32'd0);
    set_pix(109, 95, 1'b1);
    tick();
    check("addr_119", 32'(read_address), 32'd119);
    set_pix(110, 95, 1'b1);
    tick();
    check("outside_addr", 32'(read_address), 32'd0);
    set_pix(0, 0, 1'b0);
    tick();
    check("outside_is_ball", 32'(is_ball), 32'd0);
    tick();

    // Two shadow writes before the frame edge; the last one wins.
    set_we(1'b1, 3, 400, 2);
    tick();
    set_we(1'b1, 320, 240, 0);
    tick();
    set_we(1'b0, 0, 0, 0);
    check("pending_set", 32'(pos_pending), 32'd1);
    vga_vs = 1'b0;
    tick();
    check("pending_clr", 32'(pos_pending), 32'd0);
    check("commit_size0", 32'(ball_size), 32'd0);
    vga_vs = 1'b1;
    set_pix(319, 237, 1'b1);
    tick();
    check("small_addr", 32'(read_address), 32'd24);

    // Write coinciding with the VGA_VS fall commits immediately; left clip at x=0.
    set_pix(0, 0, 1'b0);
    tick();
    vga_vs = 1'b0;
    set_we(1'b1, 3, 100, 2);
    tick();
    check("direct_pending", 32'(pos_pending), 32'd0);
    check("direct_size", 32'(ball_size), 32'd2);
    set_we(1'b0, 0, 0, 0);
    vga_vs = 1'b1;
    set_pix(0, 85, 1'b1);
    tick();
    check("left_clip_addr", 32'(read_address), 32'd12);
    set_pix(0, 0, 1'b0);
    tick();
    tick();

    // Mid-frame reset drops a pending update and flushes the pipeline.
    set_we(1'b1, 50, 50, 0);
    set_pix(5, 90, 1'b1);
    tick();
    set_we(1'b0, 0, 0, 0);
    rst_n = 1'b0;
    tick();
    check("rst_out_valid0", 32'(out_valid), 32'd0);
    check("rst_pending", 32'(pos_pending), 32'd0);
    rst_n = 1'b1;
    set_pix(310, 230, 1'b1);
    tick();
    check("rst_out_valid1", 32'(out_valid), 32'd0);
    check("rst_init_addr", 32'(read_address), 32'd0);
    set_pix(0, 0, 1'b0);
    vga_vs = 1'b0;
    tick();
    check("no_commit_size", 32'(ball_size), 32'd1);
    vga_vs = 1'b1;
    tick();

    // Randomized frames: short vertical blank, then scan pixels around the ball.
    for (int f = 0; f < 30; f++) begin
      for (int b = 0; b < 4; b++) begin
        vga_vs = (b == 0) ? 1'b1 : 1'b0;
        set_pix(0, 0, 1'b0);
        if ($urandom_range(0, 3) == 0)
          set_we(1'b1, pick_coord(639), pick_coord(479), int'($urandom_range(0, 3)));
        else
          set_we(1'b0, 0, 0, 0);
        tick();
      end
      vga_vs = 1'b1;
      for (int p = 0; p < 40; p++) begin
        set_pix(clampi(com.x + int'($urandom_range(0, 44)) - 22, 0, 639),
                clampi(com.y + int'($urandom_range(0, 44)) - 22, 0, 479),
                ($urandom_range(0, 4) != 0));
        if ($urandom_range(0, 9) == 0)
          set_we(1'b1, pick_coord(639), pick_coord(479), int'($urandom_range(0, 3)));
        else
          set_we(1'b0, 0, 0, 0);
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
